prog_mem: RTL and testbench
===========================

PROG_MEM -- requirements
Module: prog_mem

Interface
- REQ-001 SHALL have parameter DATA_W, default 8: instruction word width in bits.
- REQ-002 SHALL have parameter ADDR_W, default 4: address width; depth DEPTH = 2**ADDR_W words (derived, not overridable).
- REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
- REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
- REQ-005 SHALL have port ADDRESS  input  ADDR_W  CPU fetch address.
- REQ-006 SHALL have port OUT  output  DATA_W  instruction word at ADDRESS.
- REQ-007 SHALL have port LOAD_START  input  1  request to begin a load session.
- REQ-008 SHALL have port LOAD_DATA  input  DATA_W  word to write.
- REQ-009 SHALL have port LOAD_VALID  input  1  LOAD_DATA valid.
- REQ-010 SHALL have port LOAD_LAST  input  1  qualifies the final word of a session.
- REQ-011 SHALL have port LOAD_READY  output  1  block accepts a word this cycle.
- REQ-012 SHALL have port HOLD  output  1  CPU stall request.
- REQ-013 SHALL have port LOAD_DONE  output  1  one-cycle session-complete pulse.
- REQ-014 SHALL have port LOAD_COUNT  output  ADDR_W+1  words written in the last completed session.
- REQ-015 SHALL have port CHECKSUM  output  DATA_W  sum of the last completed session's words, mod 2**DATA_W.
- REQ-016 SHALL have port ERROR  output  1  sticky protocol-error flag.

Function
- REQ-017 SHALL read OUT combinationally, with zero latency, from the array word at ADDRESS in every state.
- REQ-018 SHALL implement states IDLE, LOAD and DONE.
- REQ-019 SHALL transition IDLE->LOAD on LOAD_START=1; the write pointer and the running count/sum SHALL clear to 0 on that edge.
- REQ-020 SHALL drive LOAD_READY=1 only in LOAD; a word SHALL be accepted on any edge where LOAD_VALID&LOAD_READY.
- REQ-021 SHALL, on accept: mem[wptr]<=LOAD_DATA; wptr+1; running count +1; running sum +LOAD_DATA (mod 2**DATA_W).
- REQ-022 SHALL transition LOAD->DONE on an accept with LOAD_LAST=1, or on an accept with wptr=DEPTH-1 (full); the pointer SHALL never wrap within a session.
- REQ-023 SHALL ignore LOAD_LAST when LOAD_VALID=0.
- REQ-024 SHALL ignore LOAD_START while in LOAD or DONE.
- REQ-025 SHALL, in DONE, assert LOAD_DONE for exactly one cycle, update LOAD_COUNT and CHECKSUM from the running values on the DONE->IDLE edge, then return to IDLE.
- REQ-026 SHALL make LOAD_COUNT and CHECKSUM valid from the cycle after LOAD_DONE and hold them until the next session completes.
- REQ-027 SHALL drive HOLD=1 in LOAD and DONE, and HOLD=0 in IDLE.
- REQ-028 SHALL retain previous contents in words not written during a session.
- REQ-029 SHALL, on LOAD_START and LOAD_VALID both high in IDLE, enter LOAD without accepting that word (LOAD_READY=0) and SHALL NOT set ERROR.
- REQ-030 SHALL set ERROR on LOAD_VALID=1 in IDLE with LOAD_START=0; ERROR SHALL clear only on RESET.
- REQ-031 SHALL accept at most one word per cycle, with no wait states in LOAD.

Reset
- REQ-032 SHALL, on RESET=1 (any state, mid-session included), immediately force state IDLE, all array words 0, wptr 0, LOAD_READY 0, HOLD 0, LOAD_DONE 0, LOAD_COUNT 0, CHECKSUM 0 and ERROR 0, with OUT=0 for every ADDRESS.
- REQ-033 SHALL discard a session interrupted by RESET, with no LOAD_DONE pulse and LOAD_COUNT/CHECKSUM remaining 0.

Verification
- REQ-034 Bench SHALL cover: reset, then sweep ADDRESS 0..15 -> OUT=0x00 for all addresses, HOLD=0, ERROR=0.
- REQ-035 Bench SHALL cover: START, then 3 words 0xB3,0xB6,0xBC back-to-back with LAST on the third -> HOLD high from the cycle after START through DONE, LOAD_DONE one cycle, LOAD_COUNT=3, CHECKSUM=0x25, OUT[2]=0xBC, OUT[3]=0x00.
- REQ-036 Bench SHALL cover: START, then 16 words 0x01..0x10 with LAST never asserted -> DONE after the 16th accept, LOAD_COUNT=16, CHECKSUM=0x88, OUT[15]=0x10.
- REQ-037 Bench SHALL cover: START, with LOAD_VALID toggling 1/0 for 2 words (0xF0, LAST on 0x0F) -> only valid cycles written, LOAD_COUNT=2, CHECKSUM=0xFF.
- REQ-038 Bench SHALL cover: LOAD_VALID=1 in IDLE without START -> ERROR=1 and array unchanged; a subsequent START and 1-word load completes normally with ERROR still 1.
- REQ-039 Bench SHALL cover: RESET asserted after the 2nd word of a 5-word session -> immediate IDLE, HOLD=0, OUT=0 at addresses 0 and 1, no LOAD_DONE pulse.

Source files
------------

// File: rtl/prog_mem.sv
// Program memory with a streaming loader. The CPU reads instructions
// combinationally from the array. A loader session writes words at
// consecutive addresses from 0, stalling the CPU via HOLD while it runs.
module prog_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] OUT,
    input  logic              LOAD_START,
    input  logic [DATA_W-1:0] LOAD_DATA,
    input  logic              LOAD_VALID,
    input  logic              LOAD_LAST,
    output logic              LOAD_READY,
    output logic              HOLD,
    output logic              LOAD_DONE,
    output logic [ADDR_W:0]   LOAD_COUNT,
    output logic [DATA_W-1:0] CHECKSUM,
    output logic              ERROR
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W:0]     run_count;
    logic [DATA_W-1:0]   run_sum;
    logic                accept;

    // Checksum accumulates modulo 2**DATA_W; the carry is simply dropped.
    function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    // LOAD_READY is a registered copy of (state == LOAD), so this is the handshake.
    assign accept = LOAD_VALID && LOAD_READY;

    // Instruction fetch is a pure combinational read, independent of loader state.
    assign OUT = mem[ADDRESS];

    // Array storage: cleared on reset, written one word per accepted beat.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wptr] <= LOAD_DATA;
        end
    end

    // Loader FSM with registered handshake/status outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            wptr       <= '0;
            run_count  <= '0;
            run_sum    <= '0;
            LOAD_READY <= 1'b0;
            HOLD       <= 1'b0;
            LOAD_DONE  <= 1'b0;
            LOAD_COUNT <= '0;
            CHECKSUM   <= '0;
            ERROR      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (LOAD_START) begin
                        // A word presented together with START is not taken:
                        // READY is still low on this edge.
                        state      <= LOAD;
                        wptr       <= '0;
                        run_count  <= '0;
                        run_sum    <= '0;
                        LOAD_READY <= 1'b1;
                        HOLD       <= 1'b1;
                    end else if (LOAD_VALID) begin
                        ERROR <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wptr      <= wptr + ADDR_W'(1);
                        run_count <= run_count + (ADDR_W + 1)'(1);
                        run_sum   <= add_wrap(run_sum, LOAD_DATA);
                        // Ending on the last address keeps the pointer from wrapping.
                        if (LOAD_LAST || (wptr == ADDR_W'(DEPTH - 1))) begin
                            state      <= DONE;
                            LOAD_READY <= 1'b0;
                            LOAD_DONE  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    LOAD_DONE  <= 1'b0;
                    HOLD       <= 1'b0;
                    LOAD_COUNT <= run_count;
                    CHECKSUM   <= run_sum;
                end
                default: begin
                    state      <= IDLE;
                    LOAD_READY <= 1'b0;
                    HOLD       <= 1'b0;
                    LOAD_DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Directed testbench for prog_mem: table of expected array contents per
// phase, plus hand-written loader sessions.
`timescale 1ns/1ps
module tb_prog_mem;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] ADDRESS = '0;
    logic [7:0] OUT;
    logic       LOAD_START = 1'b0;
    logic [7:0] LOAD_DATA = '0;
    logic       LOAD_VALID = 1'b0;
    logic       LOAD_LAST = 1'b0;
    logic       LOAD_READY;
    logic       HOLD;
    logic       LOAD_DONE;
    logic [4:0] LOAD_COUNT;
    logic [7:0] CHECKSUM;
    logic       ERROR;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         phase;
        logic [3:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t tbl[$];

    prog_mem #(.DATA_W(8), .ADDR_W(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ADDRESS    (ADDRESS),
        .OUT        (OUT),
        .LOAD_START (LOAD_START),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_LAST  (LOAD_LAST),
        .LOAD_READY (LOAD_READY),
        .HOLD       (HOLD),
        .LOAD_DONE  (LOAD_DONE),
        .LOAD_COUNT (LOAD_COUNT),
        .CHECKSUM   (CHECKSUM),
        .ERROR      (ERROR)
    );

    always #50 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic void add(input int ph, input int a, input int e);
        rd_vec_t v;
        v.phase = ph;
        v.addr  = 4'(a);
        v.exp   = 8'(e);
        tbl.push_back(v);
    endfunction

    task automatic read_check(input int ph);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].phase == ph) begin
                ADDRESS = tbl[i].addr;
                #1;
                check($sformatf("out_p%0d[%0d]", ph, tbl[i].addr), OUT, tbl[i].exp);
            end
        end
    endtask

    task automatic send_words(input logic [7:0] w[$], input bit use_last, input bit gaps);
        for (int i = 0; i < w.size(); i++) begin
            check("ready_in_load", LOAD_READY, 1);
            check("hold_in_load", HOLD, 1);
            LOAD_VALID = 1'b1;
            LOAD_DATA  = w[i];
            LOAD_LAST  = use_last && (i == w.size() - 1);
            step();
            if (gaps && (i != w.size() - 1)) begin
                LOAD_VALID = 1'b0;
                LOAD_LAST  = 1'b1;
                LOAD_DATA  = 8'hAA;
                step();
            end
        end
        LOAD_VALID = 1'b0;
        LOAD_LAST  = 1'b0;
        LOAD_DATA  = '0;
    endtask

    initial begin
        logic [7:0] q[$];

        // Expected array contents for each phase of the test.
        for (int i = 0; i < 16; i++) add(0, i, 8'h00);
        add(1, 0, 8'hB3); add(1, 1, 8'hB6); add(1, 2, 8'hBC); add(1, 3, 8'h00);
        for (int i = 0; i < 16; i++) add(2, i, i + 1);
        add(3, 0, 8'hF0); add(3, 1, 8'h0F); add(3, 2, 8'h03); add(3, 15, 8'h10);
        add(4, 0, 8'hF0); add(4, 1, 8'h0F); add(4, 2, 8'h03); add(4, 3, 8'h04);
        add(5, 0, 8'h42); add(5, 1, 8'h0F); add(5, 2, 8'h03);
        add(6, 0, 8'h00); add(6, 1, 8'h00); add(6, 2, 8'h00); add(6, 15, 8'h00);

        // Reset state
        #2 RESET = 1'b1;
        #1;
        check("rst_hold", HOLD, 0);
        check("rst_ready", LOAD_READY, 0);
        check("rst_done", LOAD_DONE, 0);
        check("rst_count", LOAD_COUNT, 0);
        check("rst_checksum", CHECKSUM, 0);
        check("rst_error", ERROR, 0);
        step();
        step();
        RESET = 1'b0;
        read_check(0);
        check("idle_hold", HOLD, 0);
        check("idle_error", ERROR, 0);

        // Three-word session; START arrives together with a valid word that must be dropped
        LOAD_START = 1'b1;
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 8'hEE;
        check("ready_idle", LOAD_READY, 0);
        step();
        LOAD_START = 1'b0;
        LOAD_VALID = 1'b0;
        check("err_start_valid", ERROR, 0);
        q.delete();
        q.push_back(8'hB3); q.push_back(8'hB6); q.push_back(8'hBC);
        send_words(q, 1'b1, 1'b0);
        check("s3_done_pulse", LOAD_DONE, 1);
        check("s3_done_hold", HOLD, 1);
        check("s3_done_ready", LOAD_READY, 0);
        check("s3_count_old", LOAD_COUNT, 0);
        step();
        check("s3_done_clear", LOAD_DONE, 0);
        check("s3_hold_clear", HOLD, 0);
        check("s3_count", LOAD_COUNT, 3);
        check("s3_checksum", CHECKSUM, 8'h25);
        read_check(1);

        // Full sixteen-word session, START held high throughout (must be ignored)
        check("s16_count_held", LOAD_COUNT, 3);
        LOAD_START = 1'b1;
        step();
        q.delete();
        for (int i = 1; i <= 16; i++) q.push_back(8'(i));
        send_words(q, 1'b0, 1'b0);
        check("s16_done_pulse", LOAD_DONE, 1);
        check("s16_count_old", LOAD_COUNT, 3);
        step();
        LOAD_START = 1'b0;
        check("s16_done_clear", LOAD_DONE, 0);
        check("s16_hold_clear", HOLD, 0);
        check("s16_count", LOAD_COUNT, 16);
        check("s16_checksum", CHECKSUM, 8'h88);
        read_check(2);

        // Two words with idle gaps; LAST is high in gap cycles and must be ignored
        LOAD_START = 1'b1;
        step();
        LOAD_START = 1'b0;
        q.delete();
        q.push_back(8'hF0); q.push_back(8'h0F);
        send_words(q, 1'b1, 1'b1);
        check("gap_done_pulse", LOAD_DONE, 1);
        step();
        check("gap_count", LOAD_COUNT, 2);
        check("gap_checksum", CHECKSUM, 8'hFF);
        read_check(3);

        // Stray valid in IDLE: sticky error, no write
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 8'h55;
        step();
        LOAD_VALID = 1'b0;
        check("err_set", ERROR, 1);
        check("err_hold", HOLD, 0);
        check("err_ready", LOAD_READY, 0);
        read_check(4);
        LOAD_START = 1'b1;
        step();
        LOAD_START = 1'b0;
        q.delete();
        q.push_back(8'h42);
        send_words(q, 1'b1, 1'b0);
        check("one_done_pulse", LOAD_DONE, 1);
        step();
        check("one_count", LOAD_COUNT, 1);
        check("one_checksum", CHECKSUM, 8'h42);
        check("err_sticky", ERROR, 1);
        read_check(5);

        // Reset in the middle of a five-word session after two words
        LOAD_START = 1'b1;
        step();
        LOAD_START = 1'b0;
        q.delete();
        q.push_back(8'h11); q.push_back(8'h22);
        send_words(q, 1'b0, 1'b0);
        check("mid_hold_before", HOLD, 1);
        RESET = 1'b1;
        #1;
        check("mid_hold", HOLD, 0);
        check("mid_ready", LOAD_READY, 0);
        check("mid_done", LOAD_DONE, 0);
        check("mid_count", LOAD_COUNT, 0);
        check("mid_checksum", CHECKSUM, 0);
        check("mid_error", ERROR, 0);
        read_check(6);
        step();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_done", LOAD_DONE, 0);
            check("mid_idle_hold", HOLD, 0);
        end
        check("mid_count_after", LOAD_COUNT, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
